map_sst_ctrl: RTL
=================

MAP_SST_CTRL -- requirements
Module: map_sst_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of the save-state register address.
REQ-002 SHALL have parameter DATA_W, default 8, width of a save-state register.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a transfer.
REQ-006 SHALL have port mode  in  1  0 = save (mapper to stream), 1 = load (stream to mapper); sampled with start.
REQ-007 SHALL have port last_addr  in  ADDR_W  final register index; sampled with start.
REQ-008 SHALL have port abort  in  1  terminate the transfer immediately.
REQ-009 SHALL have port busy  out  1  transfer in progress (any state other than IDLE).
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port m2_fall  in  1  one-cycle strobe marking the mapper latch edge (M2 falling).
REQ-012 SHALL have ports sst_enable, sst_we (out, 1), sst_addr (out, ADDR_W) and sst_data_in (out, DATA_W) driving the mapper; sst_data_out (in, DATA_W) returns mapper read data.
REQ-013 SHALL have save stream ports out_valid (out, 1), out_data (out, DATA_W) and out_ready (in, 1).
REQ-014 SHALL have load stream ports in_valid (in, 1), in_data (in, DATA_W) and in_ready (out, 1).

Function
REQ-015 SHALL implement the FSM states IDLE, SAVE_RD, SAVE_PUSH, LOAD_WAIT, LOAD_WR and DONE.
REQ-016 In IDLE, start SHALL latch mode and last_addr, clear the address counter to 0, and go to SAVE_RD (mode=0) or LOAD_WAIT (mode=1); start while busy SHALL be ignored.
REQ-017 sst_enable SHALL be 1 in every state except IDLE; sst_addr SHALL equal the address counter.
REQ-018 In SAVE_RD, the block SHALL hold sst_addr for one cycle, then register sst_data_out into out_data and go to SAVE_PUSH; the first out_valid SHALL appear 2 cycles after start.
REQ-019 In SAVE_PUSH, out_valid=1 and out_data SHALL be held stable until out_ready=1; on that handshake the block SHALL go to DONE if the counter equals last_addr, otherwise increment the counter and return to SAVE_RD.
REQ-020 In LOAD_WAIT, in_ready=1; on in_valid the block SHALL register in_data onto sst_data_in and go to LOAD_WR.
REQ-021 In LOAD_WR, sst_we=1 with sst_addr and sst_data_in held stable until a cycle with m2_fall=1 (inclusive); the block SHALL then go to DONE if the counter equals last_addr, otherwise increment the counter and return to LOAD_WAIT.
REQ-022 m2_fall outside LOAD_WR SHALL have no effect; sst_we SHALL be 0 in every other state.
REQ-023 The counter SHALL be ADDR_W bits and SHALL never wrap: last_addr = 2^ADDR_W-1 terminates at that address; last_addr = 0 transfers exactly one register.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 abort SHALL take priority over every other event, including start, handshakes and m2_fall in the same cycle: the next state is IDLE, done is not pulsed, and a handshake completing in the abort cycle is not counted.
REQ-026 out_valid and in_ready SHALL never both be 1.

Reset
REQ-027 reset SHALL take priority over abort and force IDLE; counter=0, busy=0, done=0, sst_enable=0, sst_we=0, sst_addr=0, sst_data_in=0, out_valid=0, out_data=0, in_ready=0.
REQ-028 Reset asserted mid-transfer SHALL drop sst_enable and sst_we on the next edge, with no done pulse.

Structure
REQ-029 The package map_sst_pkg SHALL hold the state enum type and the default ADDR_W/DATA_W constants.
REQ-030 No sub-module SHALL be used; the FSM, counter and data registers form a single module.

Verification
REQ-031 Save, last_addr=0, mapper returns 0x05 at address 0, out_ready=1 -> out_valid at start+2 with out_data=0x05, done one cycle later, busy low after it.
REQ-032 Save, last_addr=3, out_ready low for 5 cycles per word -> out_data held stable while stalled; words for addresses 0..3 in order; exactly one done pulse.
REQ-033 Load, last_addr=1, inputs 0xA1 then 0xB2, m2_fall every 6 cycles -> sst_we held with addr 0/data 0xA1 until the m2_fall cycle, then addr 1/data 0xB2; done after the second m2_fall.
REQ-034 Load, in_valid and m2_fall high in the same cycle while in LOAD_WAIT -> data captured, m2_fall ignored; the write completes on the next m2_fall.
REQ-035 Abort in SAVE_PUSH together with out_ready=1 -> IDLE next cycle, no done, sst_enable=0; an immediate restart begins again at address 0.
REQ-036 Save, last_addr=0xFF -> 256 words transferred, counter stops at 0xFF without wrapping, single done pulse.

Source files
------------

// File: rtl/map_sst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : map_sst_pkg
// Description : Shared types and default widths for the mapper save-state
//               transfer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package map_sst_pkg;

  // Default widths of the save-state register address and data.
  localparam int c_def_addr_w = 8;
  localparam int c_def_data_w = 8;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SAVE_RD   = 3'd1,
    ST_SAVE_PUSH = 3'd2,
    ST_LOAD_WAIT = 3'd3,
    ST_LOAD_WR   = 3'd4,
    ST_DONE      = 3'd5
  } sst_state_e;

endpackage : map_sst_pkg
`default_nettype wire

// File: rtl/map_sst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : map_sst_ctrl_if
// Description : Mapper save-state bus plus the save (out) and load (in)
//               byte streams of the save-state transfer controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface map_sst_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  // Mapper save-state register port.
  logic              sst_enable;
  logic              sst_we;
  logic [ADDR_W-1:0] sst_addr;
  logic [DATA_W-1:0] sst_data_in;
  logic [DATA_W-1:0] sst_data_out;

  // Save stream (mapper to stream).
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  // Load stream (stream to mapper).
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  // Controller side.
  modport master (
    output sst_enable, sst_we, sst_addr, sst_data_in,
    input  sst_data_out,
    output out_valid, out_data,
    input  out_ready,
    input  in_valid, in_data,
    output in_ready
  );

  // Mapper / stream side.
  modport slave (
    input  sst_enable, sst_we, sst_addr, sst_data_in,
    output sst_data_out,
    input  out_valid, out_data,
    output out_ready,
    output in_valid, in_data,
    input  in_ready
  );

endinterface : map_sst_ctrl_if
`default_nettype wire

// File: rtl/map_sst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : map_sst_ctrl
// Description : Walks the mapper save-state registers 0..last_addr, either
//               reading them out onto a byte stream (save) or writing them
//               from a byte stream (load, committed on M2 falling).
// Revision    : 1.0 - initial release
// ============================================================================
module map_sst_ctrl
  import map_sst_pkg::*;
#(
  parameter int ADDR_W = c_def_addr_w,
  parameter int DATA_W = c_def_data_w
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic              m2_fall,
  map_sst_ctrl_if.master    bus
);

  sst_state_e        r_state;
  sst_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_last;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] r_wr_data;

  logic w_at_last;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_cap_rd;
  logic w_cap_wr;

  assign w_at_last = (r_cnt == r_last);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control; abort overrides everything, so a
  // handshake or m2_fall in the abort cycle leaves the counter untouched.
  // Mode is not kept separately: the branch taken at start encodes it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cap_rd    = 1'b0;
    w_cap_wr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = mode ? ST_LOAD_WAIT : ST_SAVE_RD;
        end
      end
      ST_SAVE_RD: begin
        w_cap_rd    = 1'b1;
        w_state_nxt = ST_SAVE_PUSH;
      end
      ST_SAVE_PUSH: begin
        if (bus.out_ready) begin
          if (w_at_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_inc   = 1'b1;
            w_state_nxt = ST_SAVE_RD;
          end
        end
      end
      ST_LOAD_WAIT: begin
        if (bus.in_valid) begin
          w_cap_wr    = 1'b1;
          w_state_nxt = ST_LOAD_WR;
        end
      end
      ST_LOAD_WR: begin
        if (m2_fall) begin
          if (w_at_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_inc   = 1'b1;
            w_state_nxt = ST_LOAD_WAIT;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_cap_rd    = 1'b0;
      w_cap_wr    = 1'b0;
    end
  end

  // Address counter and captured final index; the counter only advances
  // when not at last_addr, so it can never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_last <= '0;
    end else if (w_cnt_clr) begin
      r_cnt  <= '0;
      r_last <= last_addr;
    end else if (w_cnt_inc) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Data registers: mapper read data for the save stream, stream data for
  // the mapper write; both hold until the next capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data <= '0;
      r_wr_data  <= '0;
    end else begin
      if (w_cap_rd) begin
        r_out_data <= bus.sst_data_out;
      end
      if (w_cap_wr) begin
        r_wr_data <= bus.in_data;
      end
    end
  end

  // Outputs decoded from state; out_valid and in_ready come from disjoint
  // states so they can never be high together.
  assign busy            = (r_state != ST_IDLE);
  assign done            = (r_state == ST_DONE);
  assign bus.sst_enable  = (r_state != ST_IDLE);
  assign bus.sst_we      = (r_state == ST_LOAD_WR);
  assign bus.sst_addr    = r_cnt;
  assign bus.sst_data_in = r_wr_data;
  assign bus.out_valid   = (r_state == ST_SAVE_PUSH);
  assign bus.out_data    = r_out_data;
  assign bus.in_ready    = (r_state == ST_LOAD_WAIT);

endmodule : map_sst_ctrl
`default_nettype wire
